// File: rtl/regfile_wb_pkg.sv
// Shared constants for the register-file write-back sequencer.
// Describes queued entries as {word, d, val} and names the pointer-pair base registers.
package regfile_wb_pkg;

    localparam int AW_DEF = 6;
    localparam int VAL_W  = 16;

    // X/Y/Z pointer pairs start on even registers, so they are always written aligned.
    localparam logic [AW_DEF-1:0] REG_X = 6'd26;
    localparam logic [AW_DEF-1:0] REG_Y = 6'd28;
    localparam logic [AW_DEF-1:0] REG_Z = 6'd30;

    function automatic int entry_width(input int aw);
        return 1 + aw + VAL_W;
    endfunction

    localparam int ENTRY_W = entry_width(AW_DEF);

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO that holds pending write-back entries.
// Also exposes every slot in head-first order so the top can do hazard compares.
module regfile_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 23
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH*W-1:0]         view_data,
    output logic [DEPTH-1:0]           view_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Slot i of the view is the i-th oldest entry; slot 0 is always the head.
    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        logic [PW-1:0] idx;
        assign idx                  = rd_ptr + PW'(g);
        assign view_data[g*W +: W]  = mem[idx];
        assign view_valid[g]        = (CW'(g) < count);
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side sequencer for the register file: queues results, drains one write per
// cycle, splits odd-addressed 16-bit results into two byte writes, and flags pending reads.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_word,
    input  logic [AW-1:0] in_d,
    input  logic [15:0]   in_val,
    output logic          write,
    output logic          write_word,
    output logic [AW-1:0] d,
    output logic [15:0]   Rd,
    input  logic [AW-1:0] q_a,
    input  logic [AW-1:0] q_b,
    output logic          pend_a,
    output logic          pend_b
);

    localparam int EW = entry_width(AW);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_HEAD = 1'b0;
    localparam logic [0:0] ST_HIGH = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic               push;
    logic               pop;
    logic [EW-1:0]      head;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic               full;
    logic               empty;
    logic [DEPTH*EW-1:0] view_data;
    logic [DEPTH-1:0]   view_valid;
    logic               head_word;
    logic [AW-1:0]      head_d;
    logic [15:0]        head_val;
    logic               head_split;
    logic [DEPTH-1:0]   hit_a;
    logic [DEPTH-1:0]   hit_b;

    assign push = in_valid && in_ready && !full;

    regfile_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({in_word, in_d, in_val}),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .view_data  (view_data),
        .view_valid (view_valid)
    );

    assign head_word  = head[EW-1];
    assign head_d     = head[VAL_W +: AW];
    assign head_val   = head[VAL_W-1:0];
    assign head_split = head_word && head_d[0];

    // A split entry stays at the head for one extra cycle while its high byte goes out.
    always_comb begin
        pop        = 1'b0;
        state_next = state;
        if (state == ST_HIGH) begin
            pop        = 1'b1;
            state_next = ST_HEAD;
        end else if (!empty) begin
            if (head_split) begin
                state_next = ST_HIGH;
            end else begin
                pop = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_HEAD;
            in_ready   <= 1'b1;
            write      <= 1'b0;
            write_word <= 1'b0;
            d          <= '0;
            Rd         <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (count_next < CW'(DEPTH));
            if (state == ST_HIGH) begin
                write      <= 1'b1;
                write_word <= 1'b0;
                d          <= head_d + 1'b1;
                Rd         <= {8'h00, head_val[15:8]};
            end else if (!empty) begin
                write      <= 1'b1;
                write_word <= head_word && !head_d[0];
                d          <= head_d;
                Rd         <= (head_word && !head_d[0]) ? head_val : {8'h00, head_val[7:0]};
            end else begin
                write      <= 1'b0;
                write_word <= 1'b0;
            end
        end
    end

    // In HIGH the head's low byte is already written, so only its high register still counts.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hazard
        logic          e_word;
        logic [AW-1:0] e_lo;
        logic [AW-1:0] e_hi;
        logic          lo_live;
        logic          hi_live;
        assign e_word  = view_data[g*EW + EW - 1];
        assign e_lo    = view_data[g*EW + VAL_W +: AW];
        assign e_hi    = e_lo + 1'b1;
        assign lo_live = view_valid[g] && !((g == 0) && (state == ST_HIGH));
        assign hi_live = view_valid[g] && e_word;
        assign hit_a[g] = (lo_live && (q_a == e_lo)) || (hi_live && (q_a == e_hi));
        assign hit_b[g] = (lo_live && (q_b == e_lo)) || (hi_live && (q_b == e_hi));
    end

    assign pend_a = |hit_a;
    assign pend_b = |hit_b;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_regfile_writeback;
    import regfile_wb_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_word;
    logic [5:0]  in_d;
    logic [15:0] in_val;
    logic        write;
    logic        write_word;
    logic [5:0]  d;
    logic [15:0] Rd;
    logic [5:0]  q_a;
    logic [5:0]  q_b;
    logic        pend_a;
    logic        pend_b;

    int checks;
    int errors;

    regfile_writeback #(
        .DEPTH (2),
        .AW    (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_d       (in_d),
        .in_val     (in_val),
        .write      (write),
        .write_word (write_word),
        .d          (d),
        .Rd         (Rd),
        .q_a        (q_a),
        .q_b        (q_b),
        .pend_a     (pend_a),
        .pend_b     (pend_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic word, input logic [5:0] dest, input logic [15:0] val);
        in_valid = 1'b1;
        in_word  = word;
        in_d     = dest;
        in_val   = val;
    endtask

    task automatic idleInput();
        in_valid = 1'b0;
        in_word  = 1'b0;
        in_d     = '0;
        in_val   = '0;
    endtask

    task automatic expectWrite(input string tag, input logic ww, input logic [5:0] ed, input logic [15:0] erd);
        checkOutput({tag, ".write"}, write, 1'b1);
        checkOutput({tag, ".word"}, write_word, ww);
        checkOutput({tag, ".d"}, d, ed);
        checkOutput({tag, ".Rd"}, Rd, erd);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        q_a    = '0;
        q_b    = '0;
        idleInput();

        // reset then idle
        tick();
        tick();
        reset = 1'b1;
        checkOutput("rst.write", write, 1'b0);
        checkOutput("rst.in_ready", in_ready, 1'b1);
        checkOutput("rst.pend_a", pend_a, 1'b0);
        checkOutput("rst.pend_b", pend_b, 1'b0);
        tick();
        checkOutput("idle.write", write, 1'b0);

        // byte write
        applyStimulus(1'b0, 6'd5, 16'hBEEF);
        tick();
        idleInput();
        checkOutput("byte.pre", write, 1'b0);
        tick();
        expectWrite("byte", 1'b0, 6'd5, 16'h00EF);
        tick();
        checkOutput("byte.once", write, 1'b0);
        checkOutput("byte.hold_d", d, 6'd5);
        checkOutput("byte.hold_rd", Rd, 16'h00EF);

        // aligned word
        applyStimulus(1'b1, REG_X, 16'h1234);
        tick();
        idleInput();
        q_a = 6'd27;
        q_b = 6'd26;
        #1;
        checkOutput("word.pend_a", pend_a, 1'b1);
        checkOutput("word.pend_b", pend_b, 1'b1);
        tick();
        expectWrite("word", 1'b1, 6'd26, 16'h1234);
        checkOutput("word.pend_clear", pend_a, 1'b0);
        tick();
        checkOutput("word.once", write, 1'b0);

        // unaligned split
        applyStimulus(1'b1, 6'd3, 16'hA55A);
        tick();
        idleInput();
        q_a = 6'd3;
        q_b = 6'd4;
        #1;
        checkOutput("split.pre_a", pend_a, 1'b1);
        checkOutput("split.pre_b", pend_b, 1'b1);
        tick();
        expectWrite("split.lo", 1'b0, 6'd3, 16'h005A);
        checkOutput("split.high_a", pend_a, 1'b0);
        checkOutput("split.high_b", pend_b, 1'b1);
        tick();
        expectWrite("split.hi", 1'b0, 6'd4, 16'h00A5);
        checkOutput("split.done_b", pend_b, 1'b0);
        tick();
        checkOutput("split.end", write, 1'b0);

        // wrap of the high byte address
        applyStimulus(1'b1, 6'd63, 16'h0102);
        tick();
        idleInput();
        tick();
        expectWrite("wrap.lo", 1'b0, 6'd63, 16'h0002);
        tick();
        expectWrite("wrap.hi", 1'b0, 6'd0, 16'h0001);
        tick();
        checkOutput("wrap.end", write, 1'b0);

        // backpressure with two split words then a third held
        applyStimulus(1'b1, 6'd7, 16'h1111);
        tick();
        checkOutput("bp.ready1", in_ready, 1'b1);
        applyStimulus(1'b1, 6'd9, 16'h2222);
        tick();
        checkOutput("bp.full", in_ready, 1'b0);
        expectWrite("bp.w1", 1'b0, 6'd7, 16'h0011);
        q_a = 6'd7;
        q_b = 6'd10;
        #1;
        checkOutput("bp.pend_a", pend_a, 1'b0);
        checkOutput("bp.pend_b", pend_b, 1'b1);
        applyStimulus(1'b1, 6'd11, 16'h3333);
        tick();
        expectWrite("bp.w2", 1'b0, 6'd8, 16'h0011);
        checkOutput("bp.ready2", in_ready, 1'b1);
        tick();
        idleInput();
        expectWrite("bp.w3", 1'b0, 6'd9, 16'h0022);
        checkOutput("bp.full2", in_ready, 1'b0);
        tick();
        expectWrite("bp.w4", 1'b0, 6'd10, 16'h0022);
        checkOutput("bp.ready3", in_ready, 1'b1);
        tick();
        expectWrite("bp.w5", 1'b0, 6'd11, 16'h0033);
        tick();
        expectWrite("bp.w6", 1'b0, 6'd12, 16'h0033);
        tick();
        checkOutput("bp.end", write, 1'b0);

        // reset asserted during the first HIGH
        applyStimulus(1'b1, 6'd7, 16'h1111);
        tick();
        applyStimulus(1'b1, 6'd9, 16'h2222);
        tick();
        idleInput();
        expectWrite("rr.w1", 1'b0, 6'd7, 16'h0011);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("rr.write", write, 1'b0);
        checkOutput("rr.d", d, 6'd0);
        checkOutput("rr.Rd", Rd, 16'h0000);
        checkOutput("rr.ready", in_ready, 1'b1);
        q_a = 6'd9;
        q_b = 6'd8;
        #1;
        checkOutput("rr.pend_a", pend_a, 1'b0);
        checkOutput("rr.pend_b", pend_b, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rr.quiet", write, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side sequencer for the dual-read/single-write CPU register file; it is the sole driver of the register file write port.
- Buffers results from execute/load units in a small FIFO behind a valid/ready handshake and drains one register-file write per cycle.
- Splits unaligned 16-bit writes (odd d) into two byte writes, which the word-organised register RAM cannot take in one write.
- Reports pending-write hazards for the two read addresses so the issue stage can stall.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- AW, 6, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  result available.
- in_ready  out  1  FIFO can accept.
- in_word  in  1  result is 16-bit (register pair).
- in_d  in  AW  destination register (low byte of pair when in_word).
- in_val  in  16  result value; only [7:0] is meaningful when !in_word.
- write  out  1  register file write strobe.
- write_word  out  1  aligned 16-bit write.
- d  out  AW  register file write address.
- Rd  out  16  register file write data.
- q_a  in  AW  read address A to hazard-check.
- q_b  in  AW  read address B to hazard-check.
- pend_a  out  1  q_a targeted by a queued, unissued write.
- pend_b  out  1  q_b targeted by a queued, unissued write.

Behaviour:
- Reset (reset==0 at posedge): count=0, FIFO pointers=0, state=HEAD; write, write_word, d, Rd all 0; in_ready=1 next cycle. Reset mid-split abandons the high byte; a low byte already issued stays written.
- Handshake: push when in_valid && in_ready. in_ready = (count < DEPTH), registered; a pop in the same cycle does not raise in_ready until the next cycle. Push and pop in the same cycle leave count unchanged.
- Outputs are registered. An entry pushed into an empty FIFO at edge N appears on write at edge N+1, giving 1-cycle latency. The register file's last-write cache covers the read-after-write cycle; no further forwarding is done here.
- States HEAD and HIGH. Drain runs every cycle the FIFO is non-empty; it never stalls.
- HEAD, head entry byte: write=1, write_word=0, d=head.d, Rd={8'h00, val[7:0]}; pop.
- HEAD, head entry word with d[0]==0: write=1, write_word=1, d=head.d, Rd=val; pop.
- HEAD, head entry word with d[0]==1: byte write d=head.d, Rd={8'h00, val[7:0]}; no pop; go to HIGH.
- HIGH: byte write d=head.d+1 (mod 2^AW, so 63 wraps to 0), Rd={8'h00, val[15:8]}; pop; go to HEAD.
- FIFO empty in HEAD: write=0, write_word=0; d and Rd hold their previous values.
- Pending check: an entry covers d only (byte), or d and d+1 mod 2^AW (word).
  - In HIGH, the head entry covers only d+1.
  - pend_x = OR over valid entries of coverage match; combinational from FIFO state and q_x.
  - The entry being issued this cycle is already popped or reduced, so it is excluded.
- Order: writes issue strictly in push order. Duplicate destinations are allowed; the last write wins.

Decomposition:
- Shared package: AW default, register-address constants (e.g. X/Y/Z pair bases 26/28/30), and the entry record {word, d, val} width constant (1+AW+16).
- One natural sub-module: regfile_wb_fifo, a DEPTH-entry synchronous FIFO with count, full/empty, and a flat view of valid entries for the hazard compare.
- Split FSM and hazard compare stay in the top.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> write=0, in_ready=1, pend_a=pend_b=0.
- Byte write: push d=5, val=16'hBEEF, !word -> next cycle write=1, write_word=0, d=5, Rd=16'h00EF, one cycle only.
- Aligned word: push d=26, word, val=16'h1234 -> one cycle write_word=1, d=26, Rd=16'h1234; before issue, q_a=27 gives pend_a=1.
- Unaligned split: push d=3, word, val=16'hA55A -> cycle 1: d=3, Rd=16'h005A; cycle 2: d=4, Rd=16'h00A5. During cycle 2 (HIGH), q_a=3 gives pend_a=0 and q_b=4 gives pend_b=1.
- Wrap: push d=63, word, val=16'h0102 -> d=63 with Rd=16'h0002, then d=0 with Rd=16'h0001.
- Backpressure and reset: push 2 unaligned words back-to-back -> in_ready=0 with 3rd in_valid held; the 3rd is accepted only after the first pop, and all 6 writes issue in order. Repeat with reset=0 asserted during the first HIGH -> no further writes, count=0.
